dmem_stage: RTL and testbench
=============================

# dmem_stage

Parametrised, multi-cycle data-memory stage for the Y86-64 core: it replaces the single-cycle memory stage between execute and write-back. It accepts one instruction's execute results under a valid/ready handshake and performs the byte-addressed, big-endian load or store. It returns valM and a Y86 status code a configurable number of cycles later. It owns the data memory array, and stalls the upstream stage through in_ready while an access is in flight.

## Interface
- ADDR_W, 16, byte-address bits; the array holds 2^ADDR_W bytes.
- DATA_W, 64, word width in bits; must be a multiple of 8.
- LATENCY, 1, cycles from accept to result; must be ≥1.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute results present.
- in_ready  out  1  stage can accept this cycle.
- icode  in  4  Y86 instruction code.
- stat_in  in  3  upstream status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- valE  in  DATA_W  ALU result.
- valA  in  DATA_W  register A value.
- valP  in  DATA_W  next PC.
- out_valid  out  1  one-cycle result strobe.
- out_icode  out  4  latched icode.
- out_valE  out  DATA_W  latched valE.
- out_valM  out  DATA_W  load data; 0 when the instruction is not a load.
- out_stat  out  3  final status.

## Operation
- Read set:
  - mrmovq (5): address valE.
  - popq (B): address valA.
  - ret (9): address valA.
- Write set:
  - rmmovq (4): address valE, data valA.
  - pushq (A): address valE, data valA.
  - call (8): address valE, data valP.
- All other icodes perform no access.
- Byte order: the byte at address a holds word bits [DATA_W-1:DATA_W-8]; a+1 holds the next byte, and so on.
- Range check: if a + DATA_W/8 - 1 > 2^ADDR_W - 1, then out_stat=ADR (3), no write is performed, and out_valM=0.
- Status precedence:
  - A stat_in other than AOK passes through unchanged, and no access is performed.
  - Otherwise a range error gives ADR.
  - Otherwise the status is AOK.
- FSM states: IDLE, BUSY, HALTED.
  - IDLE → BUSY on in_valid && in_ready when LATENCY > 1. With LATENCY = 1 the stage stays in IDLE.
  - BUSY counts LATENCY-1 cycles, then returns to IDLE.
  - Any state → HALTED when a result is emitted with out_stat ≠ AOK. HALTED is left only by reset.
- in_ready is high in IDLE and low in BUSY and HALTED.
- The memory array is not cleared by reset; unwritten bytes read as X in simulation.

## Timing
- Reset (asynchronous, takes effect immediately):
  - out_valid=0, out_icode=0, out_valE=0, out_valM=0, out_stat=1, in_ready=1.
  - FSM=IDLE, counter=0.
- Accept edge T is the edge at which in_valid && in_ready is sampled high.
- At edge T+LATENCY-1 the write commits, the read is sampled, and the outputs register. out_valid is high for exactly the following cycle.
- With LATENCY=1, results appear at the cycle after T, in_ready stays high, and throughput is 1 per cycle.
- With LATENCY=L>1:
  - in_ready drops in the cycle after T.
  - in_ready rises in the cycle out_valid is high.
  - Throughput is one access per L cycles.
- A load that immediately follows a store to the same address returns the stored data, because the write commits before the later read edge.
- Reset during BUSY discards the pending access: no write occurs, and no out_valid is produced.

## Configuration
- DMEM_ALIGN_CHECK_EN
  - Defined: an accessed address that is not a multiple of DATA_W/8 yields out_stat=ADR, no write, and out_valM=0. The stage then enters HALTED.
  - Undefined: unaligned addresses are legal and are accessed bytewise under the big-endian rule.

## Test plan
- Store then load: with LATENCY=1, send rmmovq with valE=0x100 and valA=0x1122334455667788, then mrmovq with valE=0x100. Required: out_valM=0x1122334455667788 and out_stat=1. The byte at 0x100 must equal 0x11.
- Call and return: send call with valE=0x200 and valP=0x48, then ret with valA=0x200. Required: ret returns out_valM=0x48.
- Out of range: mrmovq with valE=0xFFFC (ADDR_W=16). Required: out_stat=3, out_valM=0, in_ready=0 thereafter until reset.
- Halt passthrough: nop with stat_in=2. Required: out_stat=2, no memory change, and the stage enters HALTED.
- Latency 3, back-to-back: hold in_valid with two stores.
  - out_valid pulses at T+3 and T+6.
  - in_ready is low for cycles T+1 through T+2.
- Reset mid-access: with LATENCY=4, apply rst_n=0 two cycles after accepting rmmovq to 0x40. Required: no out_valid, memory at 0x40 unchanged, and all outputs immediately at their reset values.

Source files
------------

// File: rtl/dmem_stage_if.sv
// Execute-to-memory handshake plus the registered result bundle of dmem_stage.
// master drives the request; slave is the memory stage.
interface dmem_stage_if #(
  parameter int DATA_W = 64
);
  // Request moves on a clock edge where in_valid && in_ready are both high.
  // While in_valid is high and in_ready is low, the upstream holds its payload stable.
  // out_valid is a one-cycle strobe with no back-pressure; the out_* fields hold until the next strobe.
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        icode;
  logic [2:0]        stat_in;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valP;
  logic              out_valid;
  logic [3:0]        out_icode;
  logic [DATA_W-1:0] out_valE;
  logic [DATA_W-1:0] out_valM;
  logic [2:0]        out_stat;

  modport master (
    output in_valid, icode, stat_in, valE, valA, valP,
    input  in_ready, out_valid, out_icode, out_valE, out_valM, out_stat
  );

  modport slave (
    input  in_valid, icode, stat_in, valE, valA, valP,
    output in_ready, out_valid, out_icode, out_valE, out_valM, out_stat
  );
endinterface

// File: rtl/dmem_stage.sv
// Multi-cycle Y86-64 data-memory stage: big-endian byte array, fixed LATENCY, ADR/halt status.
// Optional macro DMEM_ALIGN_CHECK_EN: an access to an unaligned word address reports ADR.
module dmem_stage #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_stage_if.slave bus,
  output logic [1:0] fsm_state
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_ADR = 3'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam logic [DATA_W:0]  ADDR_MAX = ((DATA_W + 1)'(1) << ADDR_W) - (DATA_W + 1)'(1);

  logic [7:0] mem [0:(1 << ADDR_W) - 1];

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic [3:0]        r_icode;
  logic [2:0]        r_stat;
  logic [DATA_W-1:0] r_valE;
  logic [DATA_W-1:0] r_valA;
  logic [DATA_W-1:0] r_valP;

  logic [3:0]        q_icode;
  logic [2:0]        q_stat;
  logic [DATA_W-1:0] q_valE;
  logic [DATA_W-1:0] q_valA;
  logic [DATA_W-1:0] q_valP;

  logic              accept;
  logic              do_access;
  logic              is_read;
  logic              is_write;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W:0]   end_addr;
  logic              range_err;
  logic              align_err;
  logic              mem_ok;
  logic              we;
  logic [2:0]        res_stat;
  logic [DATA_W-1:0] res_valM;

  assign bus.in_ready = (state == S_IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign fsm_state    = state;

  // With a single-cycle latency the access happens on the accept edge itself,
  // so the live request is used; otherwise the request latched at accept.
  always_comb begin
    q_icode = r_icode;
    q_stat  = r_stat;
    q_valE  = r_valE;
    q_valA  = r_valA;
    q_valP  = r_valP;
    if (LATENCY == 1) begin
      q_icode = bus.icode;
      q_stat  = bus.stat_in;
      q_valE  = bus.valE;
      q_valA  = bus.valA;
      q_valP  = bus.valP;
    end
  end

  always_comb begin
    if (LATENCY == 1) do_access = accept;
    else              do_access = (state == S_BUSY) && (cnt == CNT_LAST);
  end

  always_comb begin
    is_read  = (q_icode == I_MRMOVQ) || (q_icode == I_RET)  || (q_icode == I_POPQ);
    is_write = (q_icode == I_RMMOVQ) || (q_icode == I_CALL) || (q_icode == I_PUSHQ);
    addr     = ((q_icode == I_RET) || (q_icode == I_POPQ)) ? q_valA : q_valE;
    wdata    = (q_icode == I_CALL) ? q_valP : q_valA;
  end

  // Last byte address is computed one bit wider so a wrap past 2^DATA_W still reads as out of range.
  always_comb begin
    end_addr  = {1'b0, addr} + (DATA_W + 1)'(NB - 1);
    range_err = (end_addr > ADDR_MAX);
`ifdef DMEM_ALIGN_CHECK_EN
    align_err = ((addr % DATA_W'(NB)) != '0);
`else
    align_err = 1'b0;
`endif
  end

  always_comb begin
    mem_ok = (q_stat == ST_AOK) && (is_read || is_write) && !range_err && !align_err;
    if (q_stat != ST_AOK) begin
      res_stat = q_stat;
    end else if ((is_read || is_write) && (range_err || align_err)) begin
      res_stat = ST_ADR;
    end else begin
      res_stat = ST_AOK;
    end
  end

  // Big-endian: the lowest address lands in the most significant byte.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NB; i++) begin
      rdata[DATA_W - 1 - 8 * i -: 8] = mem[ADDR_W'(addr + DATA_W'(i))];
    end
  end

  assign res_valM = (mem_ok && is_read) ? rdata : '0;
  assign we       = do_access && mem_ok && is_write;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        mem[ADDR_W'(addr + DATA_W'(i))] <= wdata[DATA_W - 1 - 8 * i -: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icode <= '0;
      r_stat  <= ST_AOK;
      r_valE  <= '0;
      r_valA  <= '0;
      r_valP  <= '0;
    end else if (accept) begin
      r_icode <= bus.icode;
      r_stat  <= bus.stat_in;
      r_valE  <= bus.valE;
      r_valA  <= bus.valA;
      r_valP  <= bus.valP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_icode <= '0;
      bus.out_valE  <= '0;
      bus.out_valM  <= '0;
      bus.out_stat  <= ST_AOK;
    end else begin
      bus.out_valid <= do_access;
      if (do_access) begin
        bus.out_icode <= q_icode;
        bus.out_valE  <= q_valE;
        bus.out_valM  <= res_valM;
        bus.out_stat  <= res_stat;
      end
    end
  end

  // Any non-AOK result parks the stage in HALTED until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (do_access && (res_stat != ST_AOK)) begin
            state <= S_HALTED;
          end else if (accept && (LATENCY > 1)) begin
            state <= S_BUSY;
            cnt   <= '0;
          end
        end
        S_BUSY: begin
          if (do_access) begin
            state <= (res_stat != ST_AOK) ? S_HALTED : S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HALTED: state <= S_HALTED;
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stage.sv
// Directed bench for dmem_stage: three instances (LATENCY 1, 3, 4) with an expected-result
// queue per instance, popped by per-instance monitors on out_valid.
module tb_dmem_stage;

  localparam int W = 4 + 64 + 64 + 3;

  logic clk = 1'b0;
  logic rst1, rst3, rst4;
  logic [1:0] s1, s3, s4;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q3[$];
  logic [W-1:0] exp_q4[$];

  dmem_stage_if #(.DATA_W(64)) b1 ();
  dmem_stage_if #(.DATA_W(64)) b3 ();
  dmem_stage_if #(.DATA_W(64)) b4 ();

  dmem_stage #(.ADDR_W(16), .DATA_W(64), .LATENCY(1)) u1 (.clk(clk), .rst_n(rst1), .bus(b1), .fsm_state(s1));
  dmem_stage #(.ADDR_W(16), .DATA_W(64), .LATENCY(3)) u3 (.clk(clk), .rst_n(rst3), .bus(b3), .fsm_state(s3));
  dmem_stage #(.ADDR_W(16), .DATA_W(64), .LATENCY(4)) u4 (.clk(clk), .rst_n(rst4), .bus(b4), .fsm_state(s4));

  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_rst(input string tag, input logic v, input logic r, input logic [3:0] ic,
                         input logic [63:0] e, input logic [63:0] m, input logic [2:0] s,
                         input logic [1:0] fs);
    chk({tag, "_out_valid"}, 64'(v), 64'd0);
    chk({tag, "_in_ready"},  64'(r), 64'd1);
    chk({tag, "_out_icode"}, 64'(ic), 64'd0);
    chk({tag, "_out_valE"},  e, 64'd0);
    chk({tag, "_out_valM"},  m, 64'd0);
    chk({tag, "_out_stat"},  64'(s), 64'd1);
    chk({tag, "_state"},     64'(fs), 64'd0);
  endtask

  task automatic check_out(input int d, input logic [W-1:0] act);
    logic [W-1:0] exp;
    bit empty;
    exp = '0;
    empty = 1'b0;
    case (d)
      1: begin empty = (exp_q1.size() == 0); if (!empty) exp = exp_q1.pop_front(); end
      3: begin empty = (exp_q3.size() == 0); if (!empty) exp = exp_q3.pop_front(); end
      default: begin empty = (exp_q4.size() == 0); if (!empty) exp = exp_q4.pop_front(); end
    endcase
    n_vec++;
    if (empty) begin
      n_err++;
      $display("FAIL result_dut%0d: got unexpected out_valid with %h, required no result", d, act);
    end else if (act !== exp) begin
      n_err++;
      $display("FAIL result_dut%0d: got icode=%h valE=%h valM=%h stat=%0d, required icode=%h valE=%h valM=%h stat=%0d",
               d, act[W-1 -: 4], act[W-5 -: 64], act[66:3], act[2:0],
               exp[W-1 -: 4], exp[W-5 -: 64], exp[66:3], exp[2:0]);
    end
  endtask

  always @(negedge clk) if (b1.out_valid === 1'b1) check_out(1, {b1.out_icode, b1.out_valE, b1.out_valM, b1.out_stat});
  always @(negedge clk) if (b3.out_valid === 1'b1) check_out(3, {b3.out_icode, b3.out_valE, b3.out_valM, b3.out_stat});
  always @(negedge clk) if (b4.out_valid === 1'b1) check_out(4, {b4.out_icode, b4.out_valE, b4.out_valM, b4.out_stat});

  // ---------------- driver helpers ----------------
  task automatic drive(input int d, input logic v, input logic [3:0] ic, input logic [2:0] st,
                       input logic [63:0] e, input logic [63:0] a, input logic [63:0] p);
    case (d)
      1: begin b1.in_valid = v; b1.icode = ic; b1.stat_in = st; b1.valE = e; b1.valA = a; b1.valP = p; end
      3: begin b3.in_valid = v; b3.icode = ic; b3.stat_in = st; b3.valE = e; b3.valA = a; b3.valP = p; end
      default: begin b4.in_valid = v; b4.icode = ic; b4.stat_in = st; b4.valE = e; b4.valA = a; b4.valP = p; end
    endcase
  endtask

  function automatic logic rdy(input int d);
    case (d)
      1: return b1.in_ready;
      3: return b3.in_ready;
      default: return b4.in_ready;
    endcase
  endfunction

  task automatic push_exp(input int d, input logic [W-1:0] e);
    case (d)
      1: exp_q1.push_back(e);
      3: exp_q3.push_back(e);
      default: exp_q4.push_back(e);
    endcase
  endtask

  // One transaction: wait (bounded) for in_ready, present it, release after the accept edge.
  task automatic send(input int d, input logic [3:0] ic, input logic [2:0] st,
                      input logic [63:0] e, input logic [63:0] a, input logic [63:0] p,
                      input logic [63:0] m, input logic [2:0] ost, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (rdy(d) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rdy(d) !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_wait_dut%0d: got in_ready=%b after 50 cycles, required 1", d, rdy(d));
      return;
    end
    drive(d, 1'b1, ic, st, e, a, p);
    if (push) push_exp(d, {ic, e, m, ost});
    @(posedge clk);
    #1 drive(d, 1'b0, 4'h0, 3'd1, 64'd0, 64'd0, 64'd0);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((exp_q1.size() + exp_q3.size() + exp_q4.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_pending", 64'(exp_q1.size() + exp_q3.size() + exp_q4.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
    drive(1, 1'b0, 4'h0, 3'd1, 64'd0, 64'd0, 64'd0);
    drive(3, 1'b0, 4'h0, 3'd1, 64'd0, 64'd0, 64'd0);
    drive(4, 1'b0, 4'h0, 3'd1, 64'd0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    chk_rst("rst_l1", b1.out_valid, b1.in_ready, b1.out_icode, b1.out_valE, b1.out_valM, b1.out_stat, s1);
    chk_rst("rst_l3", b3.out_valid, b3.in_ready, b3.out_icode, b3.out_valE, b3.out_valM, b3.out_stat, s3);
    chk_rst("rst_l4", b4.out_valid, b4.in_ready, b4.out_icode, b4.out_valE, b4.out_valM, b4.out_stat, s4);
    rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;

    // LATENCY 1: store/load, call/ret, push/pop, unaligned, top-of-memory word
    send(1, 4'h4, 3'd1, 64'h100, 64'h1122334455667788, 64'h0, 64'h0, 3'd1, 1'b1);
    send(1, 4'h5, 3'd1, 64'h100, 64'h0, 64'h0, 64'h1122334455667788, 3'd1, 1'b1);
    send(1, 4'h8, 3'd1, 64'h200, 64'h0, 64'h48, 64'h0, 3'd1, 1'b1);
    send(1, 4'h9, 3'd1, 64'h208, 64'h200, 64'h0, 64'h48, 3'd1, 1'b1);
    send(1, 4'hA, 3'd1, 64'h1F8, 64'hDEADBEEFCAFEF00D, 64'h0, 64'h0, 3'd1, 1'b1);
    send(1, 4'hB, 3'd1, 64'h200, 64'h1F8, 64'h0, 64'hDEADBEEFCAFEF00D, 3'd1, 1'b1);
    send(1, 4'h4, 3'd1, 64'h301, 64'h0102030405060708, 64'h0, 64'h0, 3'd1, 1'b1);
    send(1, 4'h5, 3'd1, 64'h301, 64'h0, 64'h0, 64'h0102030405060708, 3'd1, 1'b1);
    send(1, 4'h4, 3'd1, 64'hFFF8, 64'h0F0E0D0C0B0A0908, 64'h0, 64'h0, 3'd1, 1'b1);
    send(1, 4'h5, 3'd1, 64'hFFF8, 64'h0, 64'h0, 64'h0F0E0D0C0B0A0908, 3'd1, 1'b1);
    drain();
    chk("l1_byte_100", 64'(u1.mem[16'h100]), 64'h11);
    chk("l1_byte_107", 64'(u1.mem[16'h107]), 64'h88);
    chk("l1_ready_idle", 64'(b1.in_ready), 64'd1);

    // Out of range load halts the stage; a held store must then go nowhere
    send(1, 4'h5, 3'd1, 64'hFFFC, 64'h0, 64'h0, 64'h0, 3'd3, 1'b1);
    drain();
    drive(1, 1'b1, 4'h4, 3'd1, 64'h100, 64'hFFFFFFFFFFFFFFFF, 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("l1_adr_ready", 64'(b1.in_ready), 64'd0);
      chk("l1_adr_state", 64'(s1), 64'd2);
    end
    drive(1, 1'b0, 4'h0, 3'd1, 64'd0, 64'd0, 64'd0);
    chk("l1_adr_byte_100", 64'(u1.mem[16'h100]), 64'h11);

    rst1 = 1'b0;
    #1 chk_rst("rst2_l1", b1.out_valid, b1.in_ready, b1.out_icode, b1.out_valE, b1.out_valM, b1.out_stat, s1);
    @(negedge clk) rst1 = 1'b1;

    // Halt passthrough
    send(1, 4'h1, 3'd2, 64'h100, 64'h0, 64'h0, 64'h0, 3'd2, 1'b1);
    drain();
    chk("hlt_state", 64'(s1), 64'd2);
    chk("hlt_ready", 64'(b1.in_ready), 64'd0);
    @(negedge clk) rst1 = 1'b0;
    @(negedge clk) rst1 = 1'b1;

    // Upstream INS on a store: status passes through, memory untouched
    send(1, 4'h4, 3'd4, 64'h100, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 3'd4, 1'b1);
    drain();
    chk("ins_byte_100", 64'(u1.mem[16'h100]), 64'h11);

    // LATENCY 3, back-to-back stores with in_valid held
    @(negedge clk);
    drive(3, 1'b1, 4'h4, 3'd1, 64'h300, 64'hA1A2A3A4A5A6A7A8, 64'h0);
    push_exp(3, {4'h4, 64'h300, 64'h0, 3'd1});
    @(posedge clk);
    #1 drive(3, 1'b1, 4'h4, 3'd1, 64'h308, 64'hB1B2B3B4B5B6B7B8, 64'h0);
    push_exp(3, {4'h4, 64'h308, 64'h0, 3'd1});
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("l3_ready_k%0d", k), 64'(b3.in_ready), 64'((k == 2) || (k >= 5)));
      chk($sformatf("l3_valid_k%0d", k), 64'(b3.out_valid), 64'((k == 2) || (k == 5)));
      if (k == 3) drive(3, 1'b0, 4'h0, 3'd1, 64'd0, 64'd0, 64'd0);
    end
    send(3, 4'h5, 3'd1, 64'h300, 64'h0, 64'h0, 64'hA1A2A3A4A5A6A7A8, 3'd1, 1'b1);
    send(3, 4'h5, 3'd1, 64'h308, 64'h0, 64'h0, 64'hB1B2B3B4B5B6B7B8, 3'd1, 1'b1);
    drain();

    // LATENCY 4, reset two cycles into a store
    send(4, 4'h4, 3'd1, 64'h40, 64'hA5A5A5A5A5A5A5A5, 64'h0, 64'h0, 3'd1, 1'b1);
    drain();
    send(4, 4'h4, 3'd1, 64'h40, 64'h5A5A5A5A5A5A5A5A, 64'h0, 64'h0, 3'd1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst4 = 1'b0;
    #1 chk_rst("rst_mid_l4", b4.out_valid, b4.in_ready, b4.out_icode, b4.out_valE, b4.out_valM, b4.out_stat, s4);
    repeat (3) @(negedge clk);
    rst4 = 1'b1;
    chk("l4_byte_40", 64'(u4.mem[16'h40]), 64'hA5);
    send(4, 4'h5, 3'd1, 64'h40, 64'h0, 64'h0, 64'hA5A5A5A5A5A5A5A5, 3'd1, 1'b1);
    drain();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
